// File: rtl/carregador_programa_if.sv
// carregador_programa_if: HD read bus between the program loader and the simulated disk
interface carregador_programa_if;
  logic [31:0] HD_Addr;
  logic        HD_Rd;
  logic [31:0] HD_Data;
  modport master(output HD_Addr, HD_Rd, input HD_Data);
  modport slave(input HD_Addr, HD_Rd, output HD_Data);
endinterface

// File: rtl/carregador_programa.sv
// carregador_programa: copies an HD program image into instruction RAM, then serves fetches; LOADER_STOP_ON_HALT_EN ends the copy at HALT_OP
module carregador_programa #(
  parameter int         ADDR_W  = 10,
  parameter logic [5:0] HALT_OP = 6'b111111
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [31:0]           HDBase,
  input  logic [ADDR_W:0]       ProgLen,
  carregador_programa_if.master hd,
  input  logic [31:0]           Endereco,
  output logic [31:0]           Instrucao,
  output logic                  ProcRst_n,
  output logic                  Busy,
  output logic                  Done,
  output logic [ADDR_W:0]       Loaded
);
`ifdef LOADER_STOP_ON_HALT_EN
  localparam bit STOP_EN = 1'b1;
`else
  localparam bit STOP_EN = 1'b0;
`endif
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};
  typedef enum logic [1:0] {LATCH, LOAD, DRAIN, RUN} state_t;
  state_t          state, nxt;
  logic [31:0]     base;
  logic [ADDR_W:0] len, rd_i, wr_i, plen;
  logic            pend, we, stop;
  logic [31:0]     mem [2**ADDR_W];
  assign plen = ProgLen > DEPTH ? DEPTH : ProgLen;
  // pend marks that HD_Data carries the word requested one cycle earlier
  assign we = pend && (state == LOAD || state == DRAIN);
  assign stop = STOP_EN && we && hd.HD_Data[31:26] == HALT_OP;
  assign Busy = state != RUN;
  assign hd.HD_Rd = state == LOAD;
  assign hd.HD_Addr = hd.HD_Rd ? base + 32'(rd_i) : 32'd0;
  assign Instrucao = state == RUN && Endereco[31:ADDR_W] == '0 ? mem[Endereco[ADDR_W-1:0]] : 32'd0;
  always_comb begin
    nxt = state;
    case (state)
      LATCH: nxt = plen != '0 ? LOAD : RUN;
      LOAD:  nxt = stop ? RUN : rd_i == len - ONE ? DRAIN : LOAD;
      DRAIN: nxt = RUN;
      RUN:   nxt = Start ? LATCH : RUN;
    endcase
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state     <= LATCH;
      base      <= '0;
      len       <= '0;
      rd_i      <= '0;
      wr_i      <= '0;
      pend      <= 1'b0;
      Loaded    <= '0;
      ProcRst_n <= 1'b0;
      Done      <= 1'b0;
    end else begin
      state     <= nxt;
      pend      <= hd.HD_Rd;
      ProcRst_n <= nxt == RUN;
      Done      <= nxt == RUN && state != RUN;
      rd_i      <= state == LATCH ? '0 : hd.HD_Rd ? rd_i + ONE : rd_i;
      wr_i      <= state == LATCH ? '0 : we ? wr_i + ONE : wr_i;
      Loaded    <= state == LATCH ? '0 : state == DRAIN || stop ? wr_i + ONE : Loaded;
      if (state == LATCH) begin
        base <= HDBase;
        len  <= plen;
      end
    end
  // RAM has no reset so an aborted load leaves earlier words intact
  always_ff @(posedge Clock)
    if (we) mem[wr_i[ADDR_W-1:0]] <= hd.HD_Data;
endmodule

// File: doc/carregador_programa.md
# carregador_programa

Boot/program loader and instruction store that sits directly upstream of the processor's `Instrucao` input. After reset, or on a `Start` request from the OS layer, it streams a program image from the simulated HD into on-chip instruction RAM. It holds the processor in reset while copying. It then serves instruction fetches combinationally from the processor's `Endereco`.

## Interface
Parameters:
- `ADDR_W`, 10, instruction RAM address width; depth is 2^ADDR_W words.
- `HALT_OP`, 6'b111111, opcode that marks end of program (used only with `LOADER_STOP_ON_HALT_EN`).

Ports:
- `Clock`  in  1  single system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Start`  in  1  request a (re)load; sampled only in state `RUN`.
- `HDBase`  in  32  HD word address of the first program word; latched on load entry.
- `ProgLen`  in  ADDR_W+1  number of words to copy; latched on load entry.
- `HD_Addr`  out  32  HD read address.
- `HD_Rd`  out  1  HD read strobe; data is valid on `HD_Data` exactly one cycle later.
- `HD_Data`  in  32  HD read data.
- `Endereco`  in  32  word address from the processor PC.
- `Instrucao`  out  32  instruction to the processor.
- `ProcRst_n`  out  1  active-low reset to the processor; low while not in `RUN`.
- `Busy`  out  1  high in `LATCH`, `LOAD` and `DRAIN`.
- `Done`  out  1  one-cycle pulse on the first cycle of `RUN`.
- `Loaded`  out  ADDR_W+1  words written by the last load.

## Operation
- FSM states: `LATCH`, `LOAD`, `DRAIN`, `RUN`. `Reset` low forces `LATCH`.
- **LATCH** (one cycle):
  - Capture `HDBase` into `base`.
  - Capture `min(ProgLen, 2^ADDR_W)` into `len`.
  - Clear read index `rd_i`, write index `wr_i` and `Loaded`.
  - Go to `LOAD` if `len` ≠ 0; otherwise go to `RUN`.
- **LOAD**:
  - Each cycle drive `HD_Rd`=1 and `HD_Addr = base + rd_i` (32-bit wrap), then increment `rd_i`.
  - When a read issued in the previous cycle returns, write `HD_Data` to `mem[wr_i]` and increment `wr_i`.
  - After issuing the read with `rd_i = len-1`, go to `DRAIN`.
- **DRAIN**:
  - `HD_Rd`=0.
  - Write the final returned word.
  - Set `Loaded = wr_i+1`.
  - Go to `RUN`.
- **RUN**:
  - `ProcRst_n`=1.
  - `Instrucao = mem[Endereco[ADDR_W-1:0]]` combinationally.
  - If `Endereco[31:ADDR_W]` ≠ 0, `Instrucao` = 0.
  - Words at or above `Loaded` return whatever RAM holds; RAM is not cleared on reset.
  - `Start`=1 → `LATCH`.
- Outside `RUN`: `Instrucao` = 0 (NOP), `ProcRst_n` = 0.
- `Start` is ignored outside `RUN`.
- Reset mid-load: the FSM aborts, RAM contents already written stay, and the copy restarts from word 0 after reset release.

## Timing
- Reset values:
  - state `LATCH`
  - `HD_Rd` 0, `HD_Addr` 0
  - `ProcRst_n` 0, `Busy` 1, `Done` 0, `Loaded` 0
  - `Instrucao` 0
- HD read latency is fixed at 1 cycle. One read is issued per cycle with no stalls, so there are no back-to-back hazards.
- Load of N ≥ 1 words: 1 (`LATCH`) + N (`LOAD`) + 1 (`DRAIN`) cycles. `RUN`, `Done` and `ProcRst_n`=1 all appear on cycle N+2 after `LATCH`.
- `ProgLen`=0: `RUN` on the cycle after `LATCH`.
- `ProcRst_n` and `Done` are registered. `Instrucao` in `RUN` is combinational from `Endereco` (single-cycle processor).
- Simultaneous `Start` and the `Done` cycle: `Start` is honored, and the FSM goes back to `LATCH` next cycle.

## Configuration
- Macro: `LOADER_STOP_ON_HALT_EN`.
- **Defined**: in `LOAD`/`DRAIN`, a returned word with `[31:26] == HALT_OP` is written, then the load ends.
  - No further words are written.
  - One extra read already in flight is discarded.
  - `Loaded` = index of the HALT word + 1.
  - `RUN` is entered the cycle after that write.
- **Not defined**: opcode contents are ignored and exactly `len` words are copied.

## Test plan
- Reset release with `HDBase`=0x100, `ProgLen`=4, HD returning 0xA0+addr → `HD_Addr` 0x100..0x103 on consecutive cycles. `RUN`, `Done` and `ProcRst_n`=1 appear 6 cycles after release. `Endereco`=2 reads 0xA0+0x102, and `Loaded`=4.
- `ProgLen`=0 → `RUN` on the 2nd cycle after release, `HD_Rd` never asserted, `Loaded`=0.
- `ProgLen`=2047 with `ADDR_W`=10 → exactly 1024 reads, `Loaded`=1024. `Endereco`=1024 gives `Instrucao`=0.
- In `RUN`, pulse `Start` with `HDBase`=0x200, `ProgLen`=2 → `ProcRst_n` low next cycle. `Start` pulses during `LOAD` have no effect. Words 0–1 are overwritten, and the previous word 2 is still readable.
- `Reset` asserted in the 3rd `LOAD` cycle → outputs return to reset values immediately (asynchronously). After release, the load restarts at `HDBase`+0.
- With `LOADER_STOP_ON_HALT_EN`, `ProgLen`=8 and word 3 = {`HALT_OP`, 26'h0} → `Loaded`=4, `mem[4]` untouched, and `RUN` is entered. Without the macro the same image yields `Loaded`=8.
